// File: rtl/vx_issue_sched.sv
// Round-robin warp issue scheduler: picks one eligible warp per load, pops its
// ibuffer head and holds the warp ID in a registered slot until dispatch takes it.
module vx_issue_sched #(
  parameter int NUM_WARPS     = 4,
  parameter int WID_BITS      = $clog2(NUM_WARPS),
  parameter int STALL_TIMEOUT = 100000,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_WARPS-1:0]     warp_valid,
  input  logic [NUM_WARPS-1:0]     warp_sb_ready,
  input  logic [NUM_WARPS-1:0]     warp_mask,
  output logic [NUM_WARPS-1:0]     warp_ready,
  output logic                     issue_valid,
  output logic [WID_BITS-1:0]      issue_wid,
  input  logic                     issue_ready,
  output logic                     timeout,
  output logic [PERF_CTR_BITS-1:0] perf_scb_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_disp_stalls
);

  localparam int TO_BITS = $clog2(STALL_TIMEOUT + 1);
  localparam logic [TO_BITS-1:0] TO_MAX = TO_BITS'(STALL_TIMEOUT);

  // Handshake: the slot transfers on any edge with issue_valid & issue_ready;
  // while issue_valid & ~issue_ready the slot and rr_ptr are frozen. A warp's
  // head is popped (warp_ready) only in a cycle where the slot loads it.

  logic [NUM_WARPS-1:0] eligible;
  logic                 any_eligible;
  logic                 load;
  logic                 pop;
  logic [WID_BITS-1:0]  rr_ptr;
  logic [WID_BITS-1:0]  pick;
  logic [WID_BITS-1:0]  scan_idx;
  logic                 scan_found;
  logic [TO_BITS-1:0]   stall_ctr;
  logic [TO_BITS-1:0]   stall_ctr_next;
  logic                 scb_stall;
  logic                 disp_stall;

  assign eligible     = warp_valid & warp_sb_ready & ~warp_mask;
  assign any_eligible = |eligible;
  assign load         = ~issue_valid | issue_ready;
  assign pop          = load & any_eligible & reset_n;

  // First eligible warp at or after rr_ptr, wrapping through the warp ID width.
  always_comb begin
    pick       = rr_ptr;
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      scan_idx = rr_ptr + WID_BITS'(i);
      if (!scan_found && eligible[scan_idx]) begin
        pick       = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  always_comb begin
    warp_ready = '0;
    if (pop) begin
      warp_ready[pick] = 1'b1;
    end
  end

  always_comb begin
    stall_ctr_next = stall_ctr;
    if (|warp_ready) begin
      stall_ctr_next = '0;
    end else if (|warp_valid && stall_ctr != TO_MAX) begin
      stall_ctr_next = stall_ctr + TO_BITS'(1);
    end
  end

  // Blocked by the scoreboard only counts when the slot could have loaded.
  assign scb_stall  = load & |(warp_valid & ~warp_mask) & ~any_eligible;
  assign disp_stall = issue_valid & ~issue_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_valid      <= 1'b0;
      issue_wid        <= '0;
      rr_ptr           <= '0;
      stall_ctr        <= '0;
      timeout          <= 1'b0;
      perf_scb_stalls  <= '0;
      perf_disp_stalls <= '0;
    end else begin
      if (load) begin
        issue_valid <= any_eligible;
        if (any_eligible) begin
          issue_wid <= pick;
          rr_ptr    <= pick + WID_BITS'(1);
        end
      end
      stall_ctr <= stall_ctr_next;
      timeout   <= (stall_ctr_next == TO_MAX);
      if (scb_stall) begin
        perf_scb_stalls <= perf_scb_stalls + PERF_CTR_BITS'(1);
      end
      if (disp_stall) begin
        perf_disp_stalls <= perf_disp_stalls + PERF_CTR_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_vx_issue_sched.sv
// Directed bench for vx_issue_sched: reset, single warp, round-robin, backpressure,
// scoreboard/mask blocking, stall timeout and asynchronous reset.
module tb_vx_issue_sched;

  localparam int NW  = 4;
  localparam int WB  = 2;
  localparam int PCB = 44;

  logic           clk;
  logic           reset_n;
  logic [NW-1:0]  warp_valid;
  logic [NW-1:0]  warp_sb_ready;
  logic [NW-1:0]  warp_mask;
  logic [NW-1:0]  warp_ready;
  logic           issue_valid;
  logic [WB-1:0]  issue_wid;
  logic           issue_ready;
  logic           timeout;
  logic [PCB-1:0] perf_scb_stalls;
  logic [PCB-1:0] perf_disp_stalls;

  int checks;
  int errors;

  vx_issue_sched #(
    .NUM_WARPS(NW),
    .STALL_TIMEOUT(8),
    .PERF_CTR_BITS(PCB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .warp_valid(warp_valid),
    .warp_sb_ready(warp_sb_ready),
    .warp_mask(warp_mask),
    .warp_ready(warp_ready),
    .issue_valid(issue_valid),
    .issue_wid(issue_wid),
    .issue_ready(issue_ready),
    .timeout(timeout),
    .perf_scb_stalls(perf_scb_stalls),
    .perf_disp_stalls(perf_disp_stalls)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [NW-1:0] rr_pop [5];
  logic [WB-1:0] rr_wid [5];

  initial begin
    checks = 0;
    errors = 0;
    rr_pop = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rr_wid = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // reset
    reset_n       = 1'b0;
    warp_valid    = '0;
    warp_sb_ready = '0;
    warp_mask     = '0;
    issue_ready   = 1'b0;
    tick;
    tick;
    chk("rst_valid", issue_valid, 1'b0);
    chk("rst_wid", issue_wid, 2'd0);
    chk("rst_ready", warp_ready, 4'b0000);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_scb", perf_scb_stalls, 0);
    chk("rst_disp", perf_disp_stalls, 0);

    // single warp
    @(negedge clk);
    reset_n       = 1'b1;
    warp_valid    = 4'b0001;
    warp_sb_ready = 4'b1111;
    issue_ready   = 1'b1;
    #1;
    chk("single_pop0", warp_ready, 4'b0001);
    chk("single_empty", issue_valid, 1'b0);
    tick;
    chk("single_valid1", issue_valid, 1'b1);
    chk("single_wid1", issue_wid, 2'd0);
    chk("single_pop1", warp_ready, 4'b0001);
    tick;
    chk("single_valid2", issue_valid, 1'b1);
    chk("single_wid2", issue_wid, 2'd0);

    // round-robin, rr_ptr is 1 here
    warp_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_pop", warp_ready, rr_pop[k]);
      tick;
      chk("rr_valid", issue_valid, 1'b1);
      chk("rr_wid", issue_wid, rr_wid[k]);
    end

    // backpressure: slot holds warp 1, rr_ptr is 2
    issue_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_pop", warp_ready, 4'b0000);
      tick;
      chk("bp_wid", issue_wid, 2'd1);
      chk("bp_valid", issue_valid, 1'b1);
    end
    chk("bp_disp", perf_disp_stalls, 5);
    issue_ready = 1'b1;
    #1;
    chk("bp_release_pop", warp_ready, 4'b0100);
    tick;
    chk("bp_release_wid", issue_wid, 2'd2);
    chk("bp_disp_after", perf_disp_stalls, 5);

    // scoreboard blocking
    warp_sb_ready = 4'b0000;
    #1;
    chk("scb_pop", warp_ready, 4'b0000);
    tick;
    chk("scb_drain", issue_valid, 1'b0);
    chk("scb_wid_hold", issue_wid, 2'd2);
    tick;
    tick;
    chk("scb_count", perf_scb_stalls, 3);

    // mask blocking
    warp_sb_ready = 4'b1111;
    warp_mask     = 4'b1111;
    #1;
    chk("mask_pop", warp_ready, 4'b0000);
    tick;
    tick;
    chk("mask_scb", perf_scb_stalls, 3);
    chk("mask_valid", issue_valid, 1'b0);

    // single pop to clear the stall counter, rr_ptr is 3
    warp_mask     = 4'b0000;
    warp_valid    = 4'b0001;
    warp_sb_ready = 4'b0001;
    #1;
    chk("to_prepop", warp_ready, 4'b0001);
    tick;
    chk("to_prepop_wid", issue_wid, 2'd0);

    // timeout
    warp_sb_ready = 4'b0000;
    for (int k = 0; k < 7; k++) tick;
    chk("to_before", timeout, 1'b0);
    tick;
    chk("to_rise", timeout, 1'b1);
    tick;
    chk("to_hold", timeout, 1'b1);
    chk("to_scb", perf_scb_stalls, 12);
    warp_sb_ready = 4'b0001;
    #1;
    chk("to_pop", warp_ready, 4'b0001);
    tick;
    chk("to_clear", timeout, 1'b0);
    chk("to_valid", issue_valid, 1'b1);
    chk("to_scb_after", perf_scb_stalls, 12);

    // capture warp 2 and hold it, rr_ptr is 1
    warp_valid    = 4'b0100;
    warp_sb_ready = 4'b1111;
    #1;
    chk("ar_pop", warp_ready, 4'b0100);
    tick;
    issue_ready = 1'b0;
    tick;
    chk("ar_hold_wid", issue_wid, 2'd2);
    chk("ar_disp", perf_disp_stalls, 6);

    // asynchronous reset mid-cycle
    warp_valid = 4'b1111;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", issue_valid, 1'b0);
    chk("ar_wid", issue_wid, 2'd0);
    chk("ar_ready", warp_ready, 4'b0000);
    chk("ar_disp_clr", perf_disp_stalls, 0);
    @(negedge clk);
    reset_n     = 1'b1;
    issue_ready = 1'b1;
    #1;
    chk("ar_restart_pop", warp_ready, 4'b0001);
    tick;
    chk("ar_restart_wid", issue_wid, 2'd0);
    chk("ar_restart_valid", issue_valid, 1'b1);
    chk("ar_next_pop", warp_ready, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
